// File: rtl/i281_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : i281_pkg
// Description : Shared sizes, register indices and helpers for the i281
//               register file.
// Revision    : 1.0 - initial release
// ============================================================================
package i281_pkg;

    localparam int NUM_REGS           = 4;
    localparam int REG_SEL_WIDTH      = 2;
    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam int REG_A = 0;
    localparam int REG_B = 1;
    localparam int REG_C = 2;
    localparam int REG_D = 3;

    typedef logic [NUM_REGS-1:0] wsel_t;

    // True when two or more bits are set: clearing the lowest set bit leaves something.
    function automatic logic is_multi_hot(input wsel_t sel);
        return |(sel & (sel - wsel_t'(1)));
    endfunction

endpackage : i281_pkg
`default_nettype wire

// File: rtl/i281_register_file_register_cell.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : register_cell
// Description : One DATA_WIDTH storage register with load enable and
//               asynchronous active-high clear.
// Revision    : 1.0 - initial release
// ============================================================================
module register_cell
    import i281_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_d,
    output logic [DATA_WIDTH-1:0] o_q
);

    logic [DATA_WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : register_cell
`default_nettype wire

// File: rtl/i281_register_file.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : i281_register_file
// Description : Four-entry (A..D) register file with one-hot write select,
//               two read ports, write counter, select-error flag and debug bus.
// Revision    : 1.0 - initial release
// ============================================================================
module i281_register_file
    import i281_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BYPASS     = 1,
    parameter int REG_READ   = 0
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [NUM_REGS-1:0]        Write_Select,
    input  logic [DATA_WIDTH-1:0]      Write_Data,
    input  logic [REG_SEL_WIDTH-1:0]   Read_Select_A,
    input  logic [REG_SEL_WIDTH-1:0]   Read_Select_B,
    input  logic                       Error_Clear,
    output logic [DATA_WIDTH-1:0]      Read_Data_A,
    output logic [DATA_WIDTH-1:0]      Read_Data_B,
    output logic                       Select_Error,
    output logic [7:0]                 Write_Count,
    output logic [4*DATA_WIDTH-1:0]    Debug_Registers
);

    logic                  w_illegal;
    logic                  w_valid;
    logic [NUM_REGS-1:0]   w_load;
    logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
    logic                  w_hit_a;
    logic                  w_hit_b;
    logic [7:0]            r_count;
    logic                  r_error;

    // Write classification: idle, exactly one-hot, or multi-hot (illegal).
    assign w_illegal = is_multi_hot(Write_Select);
    assign w_valid   = (|Write_Select) && !w_illegal;
    assign w_load    = Write_Select & {NUM_REGS{w_valid}};

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
            register_cell #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_cell (
                .clk    (Clock),
                .rst    (Reset),
                .i_load (w_load[i]),
                .i_d    (Write_Data),
                .o_q    (w_regs[i])
            );
        end
    endgenerate

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
        end else if (w_valid) begin
            r_count <= r_count + 8'd1;
        end
    end

    // Set has priority over clear so an error on the clearing edge is not lost.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_error <= 1'b0;
        end else if (w_illegal) begin
            r_error <= 1'b1;
        end else if (Error_Clear) begin
            r_error <= 1'b0;
        end
    end

    // A port "hits" only when a committed (valid) write targets its register.
    assign w_hit_a = w_load[Read_Select_A];
    assign w_hit_b = w_load[Read_Select_B];

    generate
        if (REG_READ != 0) begin : g_reg_read
            logic [DATA_WIDTH-1:0] r_rd_a;
            logic [DATA_WIDTH-1:0] r_rd_b;

            // Capture post-write contents, so the same-edge write is always visible.
            always_ff @(posedge Clock or posedge Reset) begin
                if (Reset) begin
                    r_rd_a <= '0;
                    r_rd_b <= '0;
                end else begin
                    r_rd_a <= w_hit_a ? Write_Data : w_regs[Read_Select_A];
                    r_rd_b <= w_hit_b ? Write_Data : w_regs[Read_Select_B];
                end
            end

            assign Read_Data_A = r_rd_a;
            assign Read_Data_B = r_rd_b;
        end else begin : g_comb_read
            assign Read_Data_A = ((BYPASS != 0) && w_hit_a) ? Write_Data : w_regs[Read_Select_A];
            assign Read_Data_B = ((BYPASS != 0) && w_hit_b) ? Write_Data : w_regs[Read_Select_B];
        end
    endgenerate

    assign Select_Error    = r_error;
    assign Write_Count     = r_count;
    assign Debug_Registers = {w_regs[REG_D], w_regs[REG_C], w_regs[REG_B], w_regs[REG_A]};

endmodule : i281_register_file
`default_nettype wire

// File: tb/tb_i281_register_file.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_i281_register_file
// Description : Directed self-checking bench; three instances cover
//               bypass/combinational, no-bypass and registered-read variants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i281_register_file;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [3:0]  ws    = 4'b0000;
    logic [7:0]  wd    = 8'h00;
    logic [1:0]  rsa   = 2'd0;
    logic [1:0]  rsb   = 2'd0;
    logic        clr   = 1'b0;

    logic [7:0]  rda0, rdb0, rda1, rdb1, rda2, rdb2;
    logic        err0, err1, err2;
    logic [7:0]  cnt0, cnt1, cnt2;
    logic [31:0] dbg0, dbg1, dbg2;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 Clock = ~Clock;

    i281_register_file #(.DATA_WIDTH(8), .BYPASS(1), .REG_READ(0)) u_dut (
        .Clock(Clock), .Reset(Reset), .Write_Select(ws), .Write_Data(wd),
        .Read_Select_A(rsa), .Read_Select_B(rsb), .Error_Clear(clr),
        .Read_Data_A(rda0), .Read_Data_B(rdb0), .Select_Error(err0),
        .Write_Count(cnt0), .Debug_Registers(dbg0));

    i281_register_file #(.DATA_WIDTH(8), .BYPASS(0), .REG_READ(0)) u_nobyp (
        .Clock(Clock), .Reset(Reset), .Write_Select(ws), .Write_Data(wd),
        .Read_Select_A(rsa), .Read_Select_B(rsb), .Error_Clear(clr),
        .Read_Data_A(rda1), .Read_Data_B(rdb1), .Select_Error(err1),
        .Write_Count(cnt1), .Debug_Registers(dbg1));

    i281_register_file #(.DATA_WIDTH(8), .BYPASS(1), .REG_READ(1)) u_regrd (
        .Clock(Clock), .Reset(Reset), .Write_Select(ws), .Write_Data(wd),
        .Read_Select_A(rsa), .Read_Select_B(rsb), .Error_Clear(clr),
        .Read_Data_A(rda2), .Read_Data_B(rdb2), .Select_Error(err2),
        .Write_Count(cnt2), .Debug_Registers(dbg2));

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick();
        #2 Reset = 1'b1;
        #1;
        tests_run++; if (dbg0 !== 32'h0) begin tests_failed++; $display("FAIL reset_dbg: got %h expected %h", dbg0, 32'h0); end
        tests_run++; if (cnt0 !== 8'h0 || err0 !== 1'b0) begin tests_failed++; $display("FAIL reset_cnt_err: got cnt=%h err=%b expected 00/0", cnt0, err0); end
        tests_run++; if (rda0 !== 8'h0 || rdb0 !== 8'h0) begin tests_failed++; $display("FAIL reset_rd_comb: got %h %h expected 00 00", rda0, rdb0); end
        tests_run++; if (rda2 !== 8'h0 || rdb2 !== 8'h0) begin tests_failed++; $display("FAIL reset_rd_reg: got %h %h expected 00 00", rda2, rdb2); end
        #2 Reset = 1'b0;
        ws = 4'b0100; wd = 8'h5A;
        tick();
        ws = 4'b0000;
        tests_run++; if (dbg0 !== 32'h005A0000) begin tests_failed++; $display("FAIL first_write_dbg: got %h expected %h", dbg0, 32'h005A0000); end
        tests_run++; if (cnt0 !== 8'd1 || cnt2 !== 8'd1) begin tests_failed++; $display("FAIL first_write_cnt: got %0d/%0d expected 1", cnt0, cnt2); end
    endtask

    task automatic test_write_read();
        ws = 4'b0001; wd = 8'h11; tick();
        ws = 4'b0010; wd = 8'h22; tick();
        ws = 4'b0100; wd = 8'h33; tick();
        ws = 4'b1000; wd = 8'h44; tick();
        ws = 4'b0000; rsa = 2'd3; rsb = 2'd0;
        #1;
        tests_run++; if (rda0 !== 8'h44 || rdb0 !== 8'h11) begin tests_failed++; $display("FAIL read_ports: got %h %h expected 44 11", rda0, rdb0); end
        tests_run++; if (dbg0 !== 32'h44332211) begin tests_failed++; $display("FAIL write_all_dbg: got %h expected %h", dbg0, 32'h44332211); end
        tick();
        tests_run++; if (rda2 !== 8'h44 || rdb2 !== 8'h11) begin tests_failed++; $display("FAIL read_ports_reg: got %h %h expected 44 11", rda2, rdb2); end
    endtask

    task automatic test_bypass();
        rsa = 2'd1; rsb = 2'd1;
        ws = 4'b0010; wd = 8'h7E;
        #1;
        tests_run++; if (rda0 !== 8'h7E || rdb0 !== 8'h7E) begin tests_failed++; $display("FAIL bypass_on: got %h %h expected 7e 7e", rda0, rdb0); end
        tests_run++; if (rda1 !== 8'h22) begin tests_failed++; $display("FAIL bypass_off_before: got %h expected 22", rda1); end
        tests_run++; if (dbg0 !== 32'h44332211) begin tests_failed++; $display("FAIL dbg_not_bypassed: got %h expected %h", dbg0, 32'h44332211); end
        tick();
        ws = 4'b0000;
        tests_run++; if (rda1 !== 8'h7E) begin tests_failed++; $display("FAIL bypass_off_after: got %h expected 7e", rda1); end
        tests_run++; if (cnt0 !== 8'd6) begin tests_failed++; $display("FAIL bypass_cnt: got %0d expected 6", cnt0); end
    endtask

    task automatic test_illegal();
        ws = 4'b0110; wd = 8'hFF;
        #1;
        tests_run++; if (rda0 !== 8'h7E) begin tests_failed++; $display("FAIL illegal_no_bypass: got %h expected 7e", rda0); end
        tick();
        ws = 4'b0000;
        tests_run++; if (dbg0 !== 32'h44337E11) begin tests_failed++; $display("FAIL illegal_dbg: got %h expected %h", dbg0, 32'h44337E11); end
        tests_run++; if (cnt0 !== 8'd6 || err0 !== 1'b1) begin tests_failed++; $display("FAIL illegal_cnt_err: got cnt=%0d err=%b expected 6/1", cnt0, err0); end
        ws = 4'b0011; clr = 1'b1;
        tick();
        tests_run++; if (err0 !== 1'b1) begin tests_failed++; $display("FAIL set_beats_clear: got %b expected 1", err0); end
        ws = 4'b0000;
        tick();
        clr = 1'b0;
        tests_run++; if (err0 !== 1'b0) begin tests_failed++; $display("FAIL error_clear: got %b expected 0", err0); end
    endtask

    task automatic test_reg_read();
        rsa = 2'd2;
        ws = 4'b0100; wd = 8'h9C;
        #1;
        tests_run++; if (rda2 !== 8'h7E) begin tests_failed++; $display("FAIL regread_before: got %h expected 7e", rda2); end
        tick();
        ws = 4'b0000;
        tests_run++; if (rda2 !== 8'h9C) begin tests_failed++; $display("FAIL regread_after: got %h expected 9c", rda2); end
        tests_run++; if (rda0 !== 8'h9C || cnt2 !== 8'd7) begin tests_failed++; $display("FAIL regread_comb_cnt: got %h cnt=%0d expected 9c/7", rda0, cnt2); end
    endtask

    task automatic test_count_wrap();
        ws = 4'b1001;
        tick();
        ws = 4'b0000;
        tests_run++; if (err0 !== 1'b1) begin tests_failed++; $display("FAIL err_before_reset: got %b expected 1", err0); end
        #2 Reset = 1'b1;
        #1;
        tests_run++; if (cnt0 !== 8'd0 || err0 !== 1'b0 || dbg0 !== 32'h0) begin tests_failed++; $display("FAIL async_reset: got cnt=%0d err=%b dbg=%h expected 0/0/0", cnt0, err0, dbg0); end
        #2 Reset = 1'b0;
        rsa = 2'd0;
        for (int i = 0; i < 256; i++) begin
            ws = 4'b0001; wd = 8'(i);
            tick();
            if (i == 254) begin
                tests_run++; if (cnt0 !== 8'd255) begin tests_failed++; $display("FAIL count_255: got %0d expected 255", cnt0); end
            end
        end
        ws = 4'b0000;
        tests_run++; if (cnt0 !== 8'd0 || rda0 !== 8'hFF) begin tests_failed++; $display("FAIL count_wrap: got cnt=%0d a=%h expected 0/ff", cnt0, rda0); end
    endtask

    task automatic test_reset_mid_write();
        for (int i = 0; i < 10; i++) begin
            ws = 4'b0010; wd = 8'hA0 + 8'(i);
            tick();
        end
        tests_run++; if (cnt0 !== 8'd10 || dbg0 !== 32'h0000A9FF) begin tests_failed++; $display("FAIL pre_reset_state: got cnt=%0d dbg=%h expected 10/0000a9ff", cnt0, dbg0); end
        wd = 8'hEE;
        #2 Reset = 1'b1;
        #1;
        tests_run++; if (cnt0 !== 8'd0 || dbg0 !== 32'h0 || rda2 !== 8'h0) begin tests_failed++; $display("FAIL mid_write_reset: got cnt=%0d dbg=%h rd=%h expected 0", cnt0, dbg0, rda2); end
        tick();
        tests_run++; if (dbg0 !== 32'h0 || cnt0 !== 8'd0) begin tests_failed++; $display("FAIL write_lost: got dbg=%h cnt=%0d expected 0/0", dbg0, cnt0); end
        #2 Reset = 1'b0;
        ws = 4'b0001; wd = 8'hAB;
        tick();
        ws = 4'b0000;
        tests_run++; if (dbg0 !== 32'h000000AB || cnt0 !== 8'd1) begin tests_failed++; $display("FAIL after_deassert: got dbg=%h cnt=%0d expected 000000ab/1", dbg0, cnt0); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_illegal();
        test_reg_read();
        test_count_wrap();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_i281_register_file
`default_nettype wire

// File: doc/i281_register_file.md
Name: i281_register_file

Overview:
- Four-entry general-purpose register file (A, B, C, D) for the i281 CPU.
- Sits directly downstream of the 2-to-4 write-select decoder and consumes its one-hot output as per-register write enables.
- Provides two read ports to the ALU/operand path and a flat debug bus for the visualizer/PONG display.
- Checks the one-hot select, counts committed writes, and flags illegal multi-hot selects.

Parameters:
- DATA_WIDTH, 8, width of each register and of data ports.
- BYPASS, 1, 1 = read port returns Write_Data when reading the register being written this cycle; 0 = returns stored (old) value.
- REG_READ, 0, 0 = combinational read ports; 1 = read ports registered (1-cycle latency).

Ports:
- Clock  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-high reset.
- Write_Select  input  4  one-hot write enable from the decoder; 0000 = no write.
- Write_Data  input  DATA_WIDTH  data written to the selected register.
- Read_Select_A  input  2  register index for read port A (0=A … 3=D).
- Read_Select_B  input  2  register index for read port B.
- Error_Clear  input  1  clears Select_Error.
- Read_Data_A  output  DATA_WIDTH  read port A.
- Read_Data_B  output  DATA_WIDTH  read port B.
- Select_Error  output  1  sticky flag: a multi-hot Write_Select was seen.
- Write_Count  output  8  number of committed writes, mod 256.
- Debug_Registers  output  4*DATA_WIDTH  {D,C,B,A}; A in the LSBs.

Behaviour:
- Reset is asynchronous, active-high, with one clock. On assertion, without waiting for a clock edge:
  - all four registers = 0
  - Read_Data_A/B = 0 when REG_READ=1; when REG_READ=0 they follow the zeroed registers
  - Select_Error = 0, Write_Count = 0, Debug_Registers = 0
- Reset mid-write: the write is lost. The first edge after deassertion behaves normally.
- Write classification, evaluated at each rising edge:
  - Write_Select = 0000: idle, nothing changes.
  - Exactly one bit i set: valid write. Register i <= Write_Data; Write_Count <= Write_Count+1, wrapping 255 -> 0.
  - Two or more bits set: illegal. No register is written, Write_Count holds, Select_Error <= 1.
- Select_Error:
  - Sticky until Reset, or until Error_Clear is high at an edge.
  - Error_Clear and an illegal select at the same edge: set wins, flag stays 1.
- Read, REG_READ=0:
  - Read_Data_X = register[Read_Select_X], combinational.
  - If BYPASS=1 and a valid write targets that same register this cycle, Read_Data_X = Write_Data.
  - Illegal selects never bypass.
- Read, REG_READ=1:
  - Read_Data_X is registered. Its value after edge n is the contents of register[Read_Select_X sampled at edge n] including any write committed at edge n, regardless of BYPASS.
- Both ports may select the same register, including while it is being written; each port independently obeys the rules above.
- Debug_Registers always shows stored contents, never bypassed data. It updates at the write edge.
- No X propagation: every output is defined from reset onward.

Decomposition:
- Shared package i281_pkg holds:
  - NUM_REGS=4, REG_SEL_WIDTH=2
  - register index constants REG_A=0, REG_B=1, REG_C=2, REG_D=3
  - DEFAULT_DATA_WIDTH=8
- One natural sub-module, register_cell: a DATA_WIDTH register with async active-high reset to 0 and a load enable. It is instantiated four times, with enables gated by the one-hot-valid check.
- The one-hot check, counter, error flag and read muxes live in the top module.

Test Plan:
- Reset asserted between clock edges -> all outputs 0 immediately. Write_Select=0100, Write_Data=0x5A for one edge -> Debug_Registers=0x005A0000, Write_Count=1.
- Write 0x11, 0x22, 0x33, 0x44 to A–D with Read_Select_A=3, Read_Select_B=0 -> Read_Data_A=0x44, Read_Data_B=0x11.
- BYPASS=1, REG_READ=0, Write_Select=0010 with 0x7E, Read_Select_A=1 in the same cycle -> Read_Data_A=0x7E before the edge. With BYPASS=0 -> old B value until the edge.
- Write_Select=0110, Write_Data=0xFF -> no register changes, Write_Count holds, Select_Error=1. Illegal select plus Error_Clear at the same edge -> stays 1. Error_Clear alone -> 0.
- 256 valid writes from reset -> Write_Count returns to 0. Reset asserted mid-sequence -> counter and registers 0 asynchronously.
- REG_READ=1: write 0x9C to C at edge n with Read_Select_A=2 -> Read_Data_A=0x9C after edge n, not before.
